pacman_sprite_draw: RTL and testbench

PACMAN_SPRITE_DRAW -- requirements
Module: pacman_sprite_draw

---
 rtl/pacman_sprite_draw_pkg.sv | 32 +++
 rtl/pacman_sprite_draw_if.sv | 28 ++
 rtl/pacman_sprite_draw_rom.sv | 48 ++++
 rtl/pacman_sprite_draw.sv | 135 +++++++++++++
 tb/tb_pacman_sprite_draw.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/pacman_sprite_draw_pkg.sv
// Shared types and constants for the Pac-Man sprite drawer.
package pacman_sprite_draw_pkg;

    // Sprite edge length in pixels (square sprite).
    localparam int SPRITE_W = 8;

    // Visible screen size, sized to match the coordinate sums.
    localparam logic [8:0] SCREEN_W = 9'd160;
    localparam logic [7:0] SCREEN_H = 8'd120;

    // Pixel colours.
    localparam logic [2:0] BG_COLOUR  = 3'b000;
    localparam logic [2:0] PAC_COLOUR = 3'b110;

    // Facing direction codes; codes above DIR_WAIT behave as DIR_WAIT.
    typedef enum logic [2:0] {
        DIR_RIGHT = 3'b000,
        DIR_UP    = 3'b001,
        DIR_LEFT  = 3'b010,
        DIR_DOWN  = 3'b011,
        DIR_WAIT  = 3'b100
    } dir_t;

    // Redraw sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ERASE = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/pacman_sprite_draw_if.sv
// Request and VGA pixel-stream bundle for the sprite drawer.
// Handshake: a request is a single-cycle go while busy=0; it is accepted on
// that rising edge and busy stays high until the cycle after done pulses.
// go while busy=1 is ignored. plot qualifies vga_x/vga_y/colour each cycle.
interface pacman_sprite_draw_if;
    logic       go;
    logic [7:0] x_in;
    logic [6:0] y_in;
    logic [2:0] dir_in;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    // Requester side (drives go and the target position).
    modport master (
        output go, x_in, y_in, dir_in,
        input  vga_x, vga_y, colour, plot, busy, done
    );

    // Drawer side.
    modport slave (
        input  go, x_in, y_in, dir_in,
        output vga_x, vga_y, colour, plot, busy, done
    );
endinterface

// File: rtl/pacman_sprite_draw_rom.sv
// Combinational 8x8 sprite bitmaps: one mouth image per direction plus a
// closed disc. Row 0 sits in the top byte, column 0 in the MSB of each row.
module pacman_sprite_rom
    import pacman_sprite_draw_pkg::*;
(
    input  logic [2:0] dir,
    input  logic [2:0] row,
    input  logic [2:0] col,
    output logic       pix
);

    localparam logic [63:0] IMG_RIGHT = {
        8'b00111100, 8'b01111110, 8'b11111100, 8'b11111000,
        8'b11111000, 8'b11111100, 8'b01111110, 8'b00111100
    };
    localparam logic [63:0] IMG_UP = {
        8'b01000010, 8'b11100111, 8'b11100111, 8'b11111111,
        8'b11111111, 8'b11111111, 8'b01111110, 8'b00111100
    };
    localparam logic [63:0] IMG_LEFT = {
        8'b00111100, 8'b01111110, 8'b00111111, 8'b00011111,
        8'b00011111, 8'b00111111, 8'b01111110, 8'b00111100
    };
    localparam logic [63:0] IMG_DOWN = {
        8'b00111100, 8'b01111110, 8'b11111111, 8'b11111111,
        8'b11111111, 8'b11100111, 8'b11100111, 8'b01000010
    };
    localparam logic [63:0] IMG_DISC = {
        8'b00111100, 8'b01111110, 8'b11111111, 8'b11111111,
        8'b11111111, 8'b11111111, 8'b01111110, 8'b00111100
    };

    logic [63:0] img;

    // Select the image by direction, then pick the bit for (row, col).
    always_comb begin
        img = IMG_DISC;
        case (dir)
            DIR_RIGHT: img = IMG_RIGHT;
            DIR_UP:    img = IMG_UP;
            DIR_LEFT:  img = IMG_LEFT;
            DIR_DOWN:  img = IMG_DOWN;
            default:   img = IMG_DISC;
        endcase
        pix = img[~{row, col}];
    end

endmodule

// File: rtl/pacman_sprite_draw.sv
// Sprite redraw sequencer: erases the previous sprite (if any) with the
// background colour, then draws the new one, one pixel per cycle.
module pacman_sprite_draw
    import pacman_sprite_draw_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
    pacman_sprite_draw_if.slave   bus,
    output state_t                state_dbg
);

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic [7:0] old_x_q, old_x_d;
    logic [6:0] old_y_q, old_y_d;
    logic       old_valid_q, old_valid_d;
    logic [7:0] new_x_q, new_x_d;
    logic [6:0] new_y_q, new_y_d;
    logic [2:0] new_dir_q, new_dir_d;

    logic [2:0] col;
    logic [2:0] row;
    logic [7:0] base_x;
    logic [6:0] base_y;
    logic [8:0] sum_x;
    logic [7:0] sum_y;
    logic       on_screen;
    logic       rom_pix;

    assign col = cnt_q[2:0];
    assign row = cnt_q[5:3];
    assign state_dbg = state_q;

    pacman_sprite_rom u_rom (
        .dir (new_dir_q),
        .row (row),
        .col (col),
        .pix (rom_pix)
    );

    // Next-state logic: capture on go in IDLE, walk 64 pixels per phase.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        old_x_d     = old_x_q;
        old_y_d     = old_y_q;
        old_valid_d = old_valid_q;
        new_x_d     = new_x_q;
        new_y_d     = new_y_q;
        new_dir_d   = new_dir_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.go) begin
                    new_x_d   = bus.x_in;
                    new_y_d   = bus.y_in;
                    new_dir_d = bus.dir_in;
                    cnt_d     = 6'd0;
                    state_d   = old_valid_q ? ST_ERASE : ST_DRAW;
                end
            end
            ST_ERASE: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd63) begin
                    cnt_d   = 6'd0;
                    state_d = ST_DRAW;
                end
            end
            ST_DRAW: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd63) begin
                    cnt_d   = 6'd0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                old_x_d     = new_x_q;
                old_y_d     = new_y_q;
                old_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 6'd0;
            old_x_q     <= 8'd0;
            old_y_q     <= 7'd0;
            old_valid_q <= 1'b0;
            new_x_q     <= 8'd0;
            new_y_q     <= 7'd0;
            new_dir_q   <= 3'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            old_x_q     <= old_x_d;
            old_y_q     <= old_y_d;
            old_valid_q <= old_valid_d;
            new_x_q     <= new_x_d;
            new_y_q     <= new_y_d;
            new_dir_q   <= new_dir_d;
        end
    end

    // Pixel address: widened sums so off-screen pixels are detected, not wrapped.
    always_comb begin
        base_x    = (state_q == ST_ERASE) ? old_x_q : new_x_q;
        base_y    = (state_q == ST_ERASE) ? old_y_q : new_y_q;
        sum_x     = {1'b0, base_x} + {6'd0, col};
        sum_y     = {1'b0, base_y} + {5'd0, row};
        on_screen = (sum_x < SCREEN_W) && (sum_y < SCREEN_H);
    end

    // Output decode; everything is zero outside the two pixel phases.
    always_comb begin
        bus.vga_x  = 8'd0;
        bus.vga_y  = 7'd0;
        bus.colour = 3'd0;
        bus.plot   = 1'b0;
        bus.busy   = (state_q != ST_IDLE);
        bus.done   = (state_q == ST_DONE);
        if (state_q == ST_ERASE || state_q == ST_DRAW) begin
            bus.vga_x  = sum_x[7:0];
            bus.vga_y  = sum_y[6:0];
            bus.plot   = on_screen;
            bus.colour = BG_COLOUR;
            if (state_q == ST_DRAW && rom_pix)
                bus.colour = PAC_COLOUR;
        end
    end

endmodule

// File: tb/tb_pacman_sprite_draw.sv
// Randomized bench for the sprite drawer: a per-cycle expected output stream
// is built from the drawing rules and compared against the DUT.
module tb_pacman_sprite_draw;
    import pacman_sprite_draw_pkg::*;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    pacman_sprite_draw_if bus();
    state_t state_dbg;

    pacman_sprite_draw dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    // Entry layout: {busy, done, plot, colour[2:0], vga_x[7:0], vga_y[6:0]}
    logic [20:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Model of what the drawer remembers between redraws.
    bit m_old_valid = 0;
    int m_old_x = 0;
    int m_old_y = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [20:0] sample();
        return {bus.busy, bus.done, bus.plot, bus.colour, bus.vga_x, bus.vga_y};
    endfunction

    function automatic logic [20:0] pack(bit busy, bit done, bit plot, logic [2:0] c, int x, int y);
        return {busy, done, plot, c, 8'(x), 7'(y)};
    endfunction

    // Reference bitmaps: row r, column c is bit [7-c] of rows[r].
    function automatic bit model_bit(int d, int r, int c);
        logic [7:0] rows [8];
        case (d)
            0: rows = '{8'b00111100, 8'b01111110, 8'b11111100, 8'b11111000,
                        8'b11111000, 8'b11111100, 8'b01111110, 8'b00111100};
            1: rows = '{8'b01000010, 8'b11100111, 8'b11100111, 8'b11111111,
                        8'b11111111, 8'b11111111, 8'b01111110, 8'b00111100};
            2: rows = '{8'b00111100, 8'b01111110, 8'b00111111, 8'b00011111,
                        8'b00011111, 8'b00111111, 8'b01111110, 8'b00111100};
            3: rows = '{8'b00111100, 8'b01111110, 8'b11111111, 8'b11111111,
                        8'b11111111, 8'b11100111, 8'b11100111, 8'b01000010};
            default: rows = '{8'b00111100, 8'b01111110, 8'b11111111, 8'b11111111,
                              8'b11111111, 8'b11111111, 8'b01111110, 8'b00111100};
        endcase
        return rows[r][7-c];
    endfunction

    // One 64-cycle phase in row-major order; off-screen pixels keep their slot.
    task automatic push_phase(input int bx, input int by, input bit is_draw, input int d);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                int sx = bx + c;
                int sy = by + r;
                bit vis = (sx < 160) && (sy < 120);
                logic [2:0] colr = BG_COLOUR;
                if (is_draw && model_bit(d, r, c)) colr = PAC_COLOUR;
                exp_q.push_back(pack(1'b1, 1'b0, vis, colr, sx, sy));
            end
        end
    endtask

    // ---------------- driver ----------------
    // Issues one go and checks every following cycle up to one idle cycle
    // after done. Optional go pulses at cycle indices pa/pb; optional reset
    // at cycle index abort_at (-1 disables).
    task automatic run_redraw(input string name, input int x, input int y, input int d,
                              input int pa, input int pb, input int abort_at);
        int i;
        logic [20:0] exp;
        exp_q.delete();
        if (m_old_valid) push_phase(m_old_x, m_old_y, 1'b0, 0);
        push_phase(x, y, 1'b1, d);
        exp_q.push_back(pack(1'b1, 1'b1, 1'b0, 3'd0, 0, 0));
        exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 3'd0, 0, 0));

        @(negedge clock);
        bus.go     = 1'b1;
        bus.x_in   = 8'(x);
        bus.y_in   = 7'(y);
        bus.dir_in = 3'(d);
        i = 0;
        while (exp_q.size() > 0) begin
            @(negedge clock);
            exp = exp_q.pop_front();
            check_eq($sformatf("%s[%0d]", name, i), 32'(sample()), 32'(exp));
            if (i == abort_at) begin
                reset_n = 1'b0;
                bus.go  = 1'b0;
                @(negedge clock);
                check_eq($sformatf("%s_after_reset", name), 32'(sample()), 32'd0);
                reset_n = 1'b1;
                exp_q.delete();
                m_old_valid = 0;
                m_old_x = 0;
                m_old_y = 0;
                return;
            end
            bus.go = (i == pa) || (i == pb);
            if (bus.go) begin
                bus.x_in   = 8'($urandom_range(0, 255));
                bus.y_in   = 7'($urandom_range(0, 127));
                bus.dir_in = 3'($urandom_range(0, 7));
            end
            i++;
        end
        m_old_valid = 1;
        m_old_x = x;
        m_old_y = y;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.go     = 1'b1;
        bus.x_in   = 8'd5;
        bus.y_in   = 7'd5;
        bus.dir_in = 3'd0;
        reset_n    = 1'b0;

        // go held high during reset must not start anything.
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check_eq($sformatf("reset[%0d]", k), 32'(sample()), 32'd0);
        end
        reset_n = 1'b1;
        bus.go  = 1'b0;
        @(negedge clock);
        check_eq("idle_after_reset", 32'(sample()), 32'd0);

        run_redraw("first",  10, 20, 0, -1, -1, -1);
        run_redraw("second", 11, 20, 0, -1, -1, -1);
        run_redraw("gopulse", 50, 60, 1, 5, 70, -1);
        run_redraw("clip",   156, 118, 2, -1, -1, -1);
        run_redraw("clip2",  156, 118, 4, -1, -1, -1);

        for (int k = 0; k < 5; k++) begin
            run_redraw($sformatf("rand%0d", k), $urandom_range(0, 255),
                       $urandom_range(0, 127), $urandom_range(0, 7), -1, -1, -1);
        end

        // Reset in the middle of DRAW (cnt=30, after a full erase phase).
        run_redraw("abort", 30, 30, 3, -1, -1, 64 + 30);
        run_redraw("post_abort", 40, 40, 4, -1, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
